// File: rtl/board_pkg.sv
// Shared board definitions for the playfield logic.
//   - Board geometry: ROWS, COLS, CELL_W, ROW_W, ROW_ID_W
//   - Row word, row index, scan pointer and count types
//   - lc_state_t: state encoding of the line clear engine
//   - score_points(): line-count to points table, only present when
//     LINECLR_SCORE_EN is defined
package board_pkg;

  localparam int ROWS     = 20;
  localparam int COLS     = 10;
  localparam int CELL_W   = 2;
  localparam int ROW_W    = COLS * CELL_W;
  localparam int ROW_ID_W = $clog2(ROWS);
  localparam int CNT_W    = $clog2(ROWS + 1);
  localparam int SCORE_W  = 16;

  typedef logic [ROW_W-1:0]    row_t;
  typedef logic [ROW_ID_W-1:0] row_id_t;
  // One extra MSB so that decrementing past row 0 is visible as underflow.
  typedef logic [ROW_ID_W:0]   ptr_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CHK,
    WR,
    FILL,
    DONE
  } lc_state_t;

`ifdef LINECLR_SCORE_EN
  function automatic logic [SCORE_W-1:0] score_points(input cnt_t n);
    logic [SCORE_W-1:0] pts;
    case (n)
      cnt_t'(0): pts = 16'd0;
      cnt_t'(1): pts = 16'd40;
      cnt_t'(2): pts = 16'd100;
      cnt_t'(3): pts = 16'd300;
      default:   pts = 16'd1200;
    endcase
    return pts;
  endfunction
`endif

endpackage

// File: rtl/line_clear_engine_row_full_check.sv
// row_full_check: combinational test of whether every cell of a row is
// occupied (a cell of value 0 is empty).
//   row  : row word to test
//   full : 1 when every CELL_W slice of row is nonzero
module row_full_check
  import board_pkg::*;
(
  input  row_t row,
  output logic full
);

  logic [COLS-1:0] cell_nz;

  for (genvar gi = 0; gi < COLS; gi++) begin : g_cell
    assign cell_nz[gi] = |row[gi*CELL_W +: CELL_W];
  end

  assign full = &cell_nz;

endmodule

// File: rtl/line_clear_engine.sv
// line_clear_engine: after a piece locks, scans board_mem bottom-up,
// removes every full row, shifts the rest down and zero-fills the top.
// Owns the board_mem port only while busy.
//   clk, reset_n   : clock (rising edge), asynchronous active-low reset
//   start          : run request, sampled only while idle
//   busy, done     : engine owns the port / one-cycle completion pulse
//   lines_cleared  : full rows removed by the last run
//   mem_rowid, mem_wnr, mem_wdata : row address, write strobe, write data
//   mem_rdata      : row read data, valid the cycle after a read address
//   score          : running score, only with LINECLR_SCORE_EN defined
// Optional feature macro: LINECLR_SCORE_EN
module line_clear_engine
  import board_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    lines_cleared,
  output logic [ROW_ID_W-1:0] mem_rowid,
  output logic                mem_wnr,
  output logic [ROW_W-1:0]    mem_wdata,
  input  logic [ROW_W-1:0]    mem_rdata
`ifdef LINECLR_SCORE_EN
  ,
  output logic [SCORE_W-1:0]  score
`endif
);

  lc_state_t state_q, state_d;
  ptr_t      src_q, src_d;
  ptr_t      dst_q, dst_d;
  cnt_t      cleared_q, cleared_d;
  cnt_t      lines_q, lines_d;
  row_t      latch_q, latch_d;

  logic row_full;
  ptr_t src_dec;
  ptr_t dst_dec;

  row_full_check u_row_full_check (
    .row  (mem_rdata),
    .full (row_full)
  );

  assign src_dec = src_q - ptr_t'(1);
  assign dst_dec = dst_q - ptr_t'(1);

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cleared_d = cleared_q;
    lines_d   = lines_q;
    latch_d   = latch_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rowid = '0;
    mem_wnr   = 1'b0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d     = ptr_t'(ROWS - 1);
          dst_d     = ptr_t'(ROWS - 1);
          cleared_d = '0;
          state_d   = RD;
        end
      end

      RD: begin
        busy      = 1'b1;
        mem_rowid = src_q[ROW_ID_W-1:0];
        state_d   = CHK;
      end

      CHK: begin
        busy    = 1'b1;
        latch_d = mem_rdata;
        if (row_full) begin
          cleared_d = cleared_q + cnt_t'(1);
          src_d     = src_dec;
        end else if (src_q == dst_q) begin
          // Row already sits where it belongs: no write needed.
          src_d = src_dec;
          dst_d = dst_dec;
        end else begin
          state_d = WR;
        end
        if (row_full || (src_q == dst_q)) begin
          // When the fill region is empty, skip FILL so no idle cycle is spent.
          if (src_d[ROW_ID_W]) state_d = dst_d[ROW_ID_W] ? DONE : FILL;
          else                 state_d = RD;
        end
      end

      WR: begin
        busy      = 1'b1;
        mem_rowid = dst_q[ROW_ID_W-1:0];
        mem_wdata = latch_q;
        mem_wnr   = 1'b1;
        src_d     = src_dec;
        dst_d     = dst_dec;
        if (src_dec[ROW_ID_W]) state_d = dst_dec[ROW_ID_W] ? DONE : FILL;
        else                   state_d = RD;
      end

      FILL: begin
        busy = 1'b1;
        if (dst_q[ROW_ID_W]) begin
          state_d = DONE;
        end else begin
          mem_rowid = dst_q[ROW_ID_W-1:0];
          mem_wnr   = 1'b1;
          dst_d     = dst_dec;
          // Leave as soon as the last (top) row has been zeroed.
          if (dst_dec[ROW_ID_W]) state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Publish the count on entry to DONE so it is stable during the pulse.
    if ((state_d == DONE) && (state_q != DONE)) lines_d = cleared_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cleared_q <= '0;
      lines_q   <= '0;
      latch_q   <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cleared_q <= cleared_d;
      lines_q   <= lines_d;
      latch_q   <= latch_d;
    end
  end

  assign lines_cleared = lines_q;

`ifdef LINECLR_SCORE_EN
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   score_sum;

  assign score_sum = {1'b0, score_q} + {1'b0, score_points(lines_q)};

  always_comb begin
    score_d = score_q;
    if (state_q == DONE) begin
      score_d = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) score_q <= '0;
    else          score_q <= score_d;
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_line_clear_engine.sv
// Testbench for line_clear_engine with a behavioural board_mem and a
// scoreboard of expected run results. Build with LINECLR_SCORE_EN defined
// to also check the score output.
module tb_line_clear_engine;
  import board_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    lines_cleared;
  logic [ROW_ID_W-1:0] mem_rowid;
  logic                mem_wnr;
  logic [ROW_W-1:0]    mem_wdata;
  row_t                mem_rdata;
`ifdef LINECLR_SCORE_EN
  logic [15:0]         score;
`endif

  line_clear_engine dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .mem_rowid     (mem_rowid),
    .mem_wnr       (mem_wnr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
`ifdef LINECLR_SCORE_EN
    ,
    .score         (score)
`endif
  );

  always #5 clk = ~clk;

  // board_mem model: registered read, write on mem_wnr, plus a bench load port.
  row_t mem [ROWS];
  logic ld_en = 1'b0;
  int   ld_row = 0;
  row_t ld_val = '0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_row] <= ld_val;
    else if (mem_wnr) mem[mem_rowid] <= mem_wdata;
    mem_rdata <= mem[mem_rowid];
  end

  int wr_cnt = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    if (mem_wnr) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int lines;
    int cycles;
    int writes;
  } exp_t;
  exp_t sb[$];

  row_t board_init [ROWS];
  row_t board_exp [ROWS];
  int   exp_score = 0;

  function automatic bit tb_full(input row_t r);
    for (int c = 0; c < COLS; c++) begin
      if (r[c*CELL_W +: CELL_W] == '0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int tb_points(input int n);
    case (n)
      0: return 0;
      1: return 40;
      2: return 100;
      3: return 300;
      default: return 1200;
    endcase
  endfunction

  task automatic load_board();
    for (int r = 0; r < ROWS; r++) begin
      ld_en  = 1'b1;
      ld_row = r;
      ld_val = board_init[r];
      @(posedge clk);
      #1;
    end
    ld_en = 1'b0;
  endtask

  task automatic clear_init();
    for (int r = 0; r < ROWS; r++) board_init[r] = '0;
  endtask

  // Reference compaction: keep non-full rows in bottom-up order, zero the rest.
  task automatic push_expected();
    exp_t e;
    int   d;
    int   lines;
    int   shifts;
    d = ROWS - 1;
    lines = 0;
    shifts = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (tb_full(board_init[r])) begin
        lines++;
      end else begin
        if (r != d) shifts++;
        board_exp[d] = board_init[r];
        d--;
      end
    end
    for (int r = d; r >= 0; r--) board_exp[r] = '0;
    e.lines  = lines;
    e.cycles = 2 * ROWS + shifts + lines;
    e.writes = shifts + lines;
    sb.push_back(e);
    exp_score = exp_score + tb_points(lines);
    if (exp_score > 16'hFFFF) exp_score = 16'hFFFF;
  endtask

  task automatic run_board(input string name, input bit inject);
    exp_t e;
    int   cycles;
    int   wr_base;
    int   done_base;
    int   bad_rows;
    push_expected();
    load_board();
    @(negedge clk);
    wr_base   = wr_cnt;
    done_base = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 300) begin
      if (busy) cycles++;
      start = inject && (cycles == 10);
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_done_seen"}, {31'd0, done}, 32'd1);
    e = sb.pop_front();
    check({name, "_lines"}, 32'(lines_cleared), 32'(e.lines));
    check({name, "_cycles"}, 32'(cycles), 32'(e.cycles));
    check({name, "_writes"}, 32'(wr_cnt - wr_base), 32'(e.writes));
    check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check({name, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
    check({name, "_lines_held"}, 32'(lines_cleared), 32'(e.lines));
    bad_rows = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (mem[r] !== board_exp[r]) bad_rows++;
      check($sformatf("%s_row%0d", name, r), 32'(mem[r]), 32'(board_exp[r]));
    end
`ifdef LINECLR_SCORE_EN
    check({name, "_score"}, 32'(score), 32'(exp_score));
`endif
    $display("run %s: lines=%0d cycles=%0d writes=%0d bad_rows=%0d",
             name, lines_cleared, cycles, wr_cnt - wr_base, bad_rows);
  endtask

  initial begin
    int waited;
    reset_n = 1'b0;
    clear_init();
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wnr", {31'd0, mem_wnr}, 32'd0);
    check("rst_rowid", 32'(mem_rowid), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
`ifdef LINECLR_SCORE_EN
    check("rst_score", 32'(score), 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    // Empty board.
    clear_init();
    run_board("empty", 1'b0);

    // One full bottom row, one partial row above it.
    clear_init();
    board_init[19] = 20'h55555;
    board_init[18] = 20'h00003;
    run_board("one_line", 1'b0);

    // Bottom row with cell 0 empty is not full.
    clear_init();
    board_init[19] = 20'h55554;
    run_board("near_full", 1'b0);

    // Four full rows under a partial row.
    clear_init();
    for (int r = 16; r < 20; r++) board_init[r] = 20'hAAAAA;
    board_init[15] = 20'h00F00;
    run_board("tetris", 1'b0);

    // Every row full.
    for (int r = 0; r < ROWS; r++) board_init[r] = 20'hFFFFF;
    run_board("all_full", 1'b0);

    // Start pulse while busy must be ignored.
    clear_init();
    board_init[19] = 20'h55555;
    board_init[18] = 20'h00003;
    run_board("ignored_start", 1'b1);

    // Random boards mixing full, empty and partial rows.
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        case ($urandom_range(0, 2))
          0: board_init[r] = '0;
          1: for (int c = 0; c < COLS; c++) board_init[r][c*CELL_W +: CELL_W] = 2'($urandom_range(1, 3));
          default: board_init[r] = row_t'($urandom);
        endcase
      end
      run_board($sformatf("random%0d", t), 1'b0);
    end

    // Reset during a shift write abandons the run.
    clear_init();
    board_init[19] = 20'h55555;
    board_init[18] = 20'h00003;
    load_board();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!mem_wnr && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    check("rst_mid_reached_wr", {31'd0, mem_wnr}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_wnr", {31'd0, mem_wnr}, 32'd0);
    check("rst_mid_lines", 32'(lines_cleared), 32'd0);
    $display("run reset_mid_wr: waited=%0d busy=%0b wnr=%0b", waited, busy, mem_wnr);
    exp_score = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_board("after_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
